// File: rtl/snake_pkg.sv
// snake_pkg: constants shared by the snake game logic, score_keeper and display.
//   SCORE_W : width of the score value carried to the 7-segment display.
//   state_t : score_keeper round FSM encoding (S_IDLE, S_PLAY, S_OVER).
package snake_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: event and result bundle between the game logic and score_keeper.
//   start, eat, game_over             : game events (driven by master)
//   score, best, disp_value, new_best,
//   playing                           : score results (driven by slave)
interface score_keeper_if #(
  parameter int SCORE_W = snake_pkg::SCORE_W
);

  logic               start;
  logic               eat;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best;
  logic               new_best;
  logic               playing;
  logic [SCORE_W-1:0] disp_value;

  modport master (
    output start, eat, game_over,
    input  score, best, new_best, playing, disp_value
  );

  modport slave (
    input  start, eat, game_over,
    output score, best, new_best, playing, disp_value
  );

endinterface

// File: rtl/blink_timer.sv
// blink_timer: free-running phase toggler for the game-over display blink.
//   clk65MHz : main clock
//   rst      : synchronous active-high reset
//   clear    : synchronous restart (counter and phase to 0), wins over enable
//   enable   : count while high
//   phase    : toggles every BLINK_CYCLES enabled cycles
module blink_timer #(
  parameter int BLINK_CYCLES = 32_500_000
) (
  input  logic clk65MHz,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic phase
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             phase_r;

  // Phase counter: wraps at LAST and flips the phase on the wrap.
  always_ff @(posedge clk65MHz) begin
    if (rst || clear) begin
      cnt_r   <= {CNT_W{1'b0}};
      phase_r <= 1'b0;
    end else if (enable) begin
      if (cnt_r == LAST) begin
        cnt_r   <= {CNT_W{1'b0}};
        phase_r <= ~phase_r;
      end else begin
        cnt_r   <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r   <= cnt_r;
      phase_r <= phase_r;
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/score_keeper.sv
// score_keeper: counts food events per round, keeps the session best score and
// selects the value shown on the 7-segment display.
//   clk65MHz : main clock
//   rst      : synchronous active-high reset
//   bus      : score_keeper_if slave (events in, score results out)
module score_keeper
  import snake_pkg::*;
#(
  parameter int SCORE_W      = snake_pkg::SCORE_W,
  parameter int SCORE_MAX    = 15,
  parameter int BLINK_CYCLES = 32_500_000
) (
  input  logic           clk65MHz,
  input  logic           rst,
  score_keeper_if.slave  bus
);

  localparam logic [SCORE_W-1:0] SAT = SCORE_W'(SCORE_MAX);

  state_t             state_r;
  logic [SCORE_W-1:0] score_r;
  logic [SCORE_W-1:0] best_r;
  logic               new_best_r;
  logic               playing_r;
  logic               eat_q_r;
  logic               eat_rise_s;
  logic               blink_clear_s;
  logic               blink_enable_s;
  logic               phase_s;

  // eat_q is tracked in every state, so a held eat never counts on entry to PLAY.
  assign eat_rise_s = bus.eat & ~eat_q_r;

  // Blink timer only runs in OVER; leaving (start) or any other state restarts it.
  assign blink_enable_s = (state_r == S_OVER);
  assign blink_clear_s  = (state_r != S_OVER) | bus.start;

  // Round FSM with score, best and status registers.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_r    <= S_IDLE;
      score_r    <= {SCORE_W{1'b0}};
      best_r     <= {SCORE_W{1'b0}};
      new_best_r <= 1'b0;
      playing_r  <= 1'b0;
      eat_q_r    <= 1'b0;
    end else begin
      eat_q_r <= bus.eat;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            state_r   <= S_PLAY;
            playing_r <= 1'b1;
            score_r   <= {SCORE_W{1'b0}};
          end
        end
        S_PLAY: begin
          // game_over beats a coincident eat edge; best uses the pre-event score.
          if (bus.game_over) begin
            state_r   <= S_OVER;
            playing_r <= 1'b0;
            if (score_r > best_r) begin
              best_r     <= score_r;
              new_best_r <= 1'b1;
            end
          end else if (eat_rise_s && (score_r != SAT)) begin
            score_r <= score_r + SCORE_W'(1);
          end
        end
        S_OVER: begin
          if (bus.start) begin
            state_r    <= S_PLAY;
            playing_r  <= 1'b1;
            score_r    <= {SCORE_W{1'b0}};
            new_best_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          playing_r <= 1'b0;
        end
      endcase
    end
  end

  blink_timer #(
    .BLINK_CYCLES (BLINK_CYCLES)
  ) u_blink (
    .clk65MHz (clk65MHz),
    .rst      (rst),
    .clear    (blink_clear_s),
    .enable   (blink_enable_s),
    .phase    (phase_s)
  );

  assign bus.score      = score_r;
  assign bus.best       = best_r;
  assign bus.new_best   = new_best_r;
  assign bus.playing    = playing_r;
  assign bus.disp_value = ((state_r == S_OVER) && phase_s) ? best_r : score_r;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed scenarios plus random stimulus against a
// rule-level reference model of the score keeper.
module tb_score_keeper;

  localparam int SW   = 4;
  localparam int SMAX = 15;
  localparam int BC   = 4;

  logic clk65MHz = 1'b0;
  logic rst      = 1'b0;

  score_keeper_if #(.SCORE_W(SW)) bus ();

  score_keeper #(
    .SCORE_W      (SW),
    .SCORE_MAX    (SMAX),
    .BLINK_CYCLES (BC)
  ) dut (
    .clk65MHz (clk65MHz),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk65MHz = ~clk65MHz;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: round status, scores and cycles spent in game over.
  int m_score, m_best, m_over_cycles;
  bit m_new_best, m_playing, m_over, m_eat_prev;

  task automatic model_step();
    bit rise;
    rise = bus.eat && !m_eat_prev;
    if (rst) begin
      m_score = 0; m_best = 0; m_new_best = 0; m_playing = 0;
      m_over = 0; m_eat_prev = 0; m_over_cycles = 0;
    end else begin
      m_eat_prev = bus.eat;
      if (m_playing) begin
        if (bus.game_over) begin
          m_playing = 0; m_over = 1; m_over_cycles = 0;
          if (m_score > m_best) begin m_best = m_score; m_new_best = 1; end
        end else if (rise && m_score < SMAX) begin
          m_score = m_score + 1;
        end
      end else if (m_over) begin
        if (bus.start) begin
          m_over = 0; m_playing = 1; m_score = 0; m_new_best = 0;
        end else begin
          m_over_cycles = m_over_cycles + 1;
        end
      end else if (bus.start) begin
        m_playing = 1; m_score = 0;
      end
    end
  endtask

  function automatic int exp_disp();
    if (m_over && ((m_over_cycles / BC) % 2 == 1)) return m_best;
    return m_score;
  endfunction

  // One clock edge; model sees the same inputs; outputs settle 1 ns later.
  task automatic tick();
    @(posedge clk65MHz);
    model_step();
    #1;
  endtask

  task automatic drive(input bit s, input bit e, input bit g);
    bus.start = s; bus.eat = e; bus.game_over = g;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(0, 0, 0); tick(); rst = 1'b0;
  endtask

  // start, n single-cycle eat pulses, game_over.
  task automatic play_round(input int n);
    drive(1, 0, 0); tick();
    drive(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      bus.eat = 1'b1; tick(); bus.eat = 1'b0; tick();
    end
    drive(0, 0, 1); tick(); drive(0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 1, 0); do_reset(); drive(0, 0, 0);
    n_vec++; if (bus.score !== 4'd0) begin n_err++; $display("FAIL reset_score got %0d want 0", bus.score); end
    n_vec++; if (bus.best !== 4'd0) begin n_err++; $display("FAIL reset_best got %0d want 0", bus.best); end
    n_vec++; if (bus.new_best !== 1'b0) begin n_err++; $display("FAIL reset_new_best got %0b want 0", bus.new_best); end
    n_vec++; if (bus.playing !== 1'b0) begin n_err++; $display("FAIL reset_playing got %0b want 0", bus.playing); end
    n_vec++; if (bus.disp_value !== 4'd0) begin n_err++; $display("FAIL reset_disp got %0d want 0", bus.disp_value); end
  endtask

  task automatic test_count();
    int lens[3] = '{1, 5, 2};
    do_reset();
    drive(1, 0, 0); tick(); drive(0, 0, 0); tick();
    foreach (lens[p]) begin
      for (int c = 0; c <= lens[p]; c++) begin
        bus.eat = (c < lens[p]); tick();
        n_vec++;
        if (bus.playing !== 1'b1 || bus.best !== 4'd0) begin
          n_err++; $display("FAIL count_status playing=%0b best=%0d want 1/0", bus.playing, bus.best);
        end
      end
    end
    n_vec++; if (bus.score !== 4'd3) begin n_err++; $display("FAIL count_score got %0d want 3", bus.score); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, 0, 0); tick(); drive(0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      bus.eat = 1'b1; tick(); bus.eat = 1'b0; tick();
      n_vec++;
      if (bus.score !== 4'((i > 15) ? 15 : i)) begin
        n_err++; $display("FAIL sat_score edge %0d got %0d want %0d", i, bus.score, (i > 15) ? 15 : i);
      end
    end
    drive(0, 0, 1); tick(); drive(0, 0, 0);
    n_vec++; if (bus.best !== 4'd15) begin n_err++; $display("FAIL sat_best got %0d want 15", bus.best); end
    n_vec++; if (bus.new_best !== 1'b1) begin n_err++; $display("FAIL sat_new_best got %0b want 1", bus.new_best); end
  endtask

  task automatic test_rounds();
    do_reset();
    play_round(5);
    play_round(3);
    n_vec++; if (bus.best !== 4'd5) begin n_err++; $display("FAIL rounds_best got %0d want 5", bus.best); end
    n_vec++; if (bus.new_best !== 1'b0) begin n_err++; $display("FAIL rounds_new_best got %0b want 0", bus.new_best); end
    drive(1, 0, 0); tick(); drive(0, 0, 0);
    n_vec++; if (bus.score !== 4'd0 || bus.best !== 4'd5) begin
      n_err++; $display("FAIL rounds_restart score=%0d best=%0d want 0/5", bus.score, bus.best);
    end
  endtask

  task automatic test_blink();
    do_reset();
    play_round(7);
    play_round(2);
    for (int i = 0; i < 17; i++) begin
      n_vec++;
      if (bus.disp_value !== 4'(((i % 8) < 4) ? 2 : 7)) begin
        n_err++; $display("FAIL blink_disp cycle %0d got %0d want %0d", i, bus.disp_value, ((i % 8) < 4) ? 2 : 7);
      end
      bus.game_over = (i == 9); tick();
    end
    bus.game_over = 1'b0;
    drive(1, 0, 0); tick(); drive(0, 0, 0);
    n_vec++; if (bus.disp_value !== 4'd0 || bus.playing !== 1'b1) begin
      n_err++; $display("FAIL blink_restart disp=%0d playing=%0b want 0/1", bus.disp_value, bus.playing);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    play_round(3);
    drive(1, 0, 0); tick(); drive(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.eat = 1'b1; tick(); bus.eat = 1'b0; tick();
    end
    drive(0, 1, 1); tick(); drive(0, 0, 0); tick();
    n_vec++; if (bus.score !== 4'd4) begin n_err++; $display("FAIL coinc_score got %0d want 4", bus.score); end
    n_vec++; if (bus.playing !== 1'b0) begin n_err++; $display("FAIL coinc_state playing=%0b want 0", bus.playing); end
    n_vec++; if (bus.best !== 4'd4 || bus.new_best !== 1'b1) begin
      n_err++; $display("FAIL coinc_best best=%0d new=%0b want 4/1", bus.best, bus.new_best);
    end
    // OVER: start and game_over together, start wins.
    drive(1, 0, 1); tick(); drive(0, 0, 0);
    n_vec++; if (bus.playing !== 1'b1 || bus.score !== 4'd0 || bus.new_best !== 1'b0) begin
      n_err++; $display("FAIL coinc_start playing=%0b score=%0d new=%0b want 1/0/0", bus.playing, bus.score, bus.new_best);
    end
  endtask

  task automatic test_rst_over();
    do_reset();
    play_round(9);
    n_vec++; if (bus.best !== 4'd9) begin n_err++; $display("FAIL rstover_best got %0d want 9", bus.best); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if ({bus.score, bus.best, bus.new_best, bus.playing, bus.disp_value} !== 14'd0) begin
      n_err++; $display("FAIL rstover_outputs score=%0d best=%0d new=%0b play=%0b disp=%0d want all 0",
                        bus.score, bus.best, bus.new_best, bus.playing, bus.disp_value);
    end
    bus.eat = 1'b1; tick(); bus.eat = 1'b0; tick();
    n_vec++; if (bus.score !== 4'd0 || bus.playing !== 1'b0) begin
      n_err++; $display("FAIL rstover_idle_eat score=%0d playing=%0b want 0/0", bus.score, bus.playing);
    end
    // eat held across entry to PLAY must not count until it re-rises.
    bus.eat = 1'b1; tick(); bus.start = 1'b1; tick(); bus.start = 1'b0; tick(); tick();
    n_vec++; if (bus.score !== 4'd0) begin n_err++; $display("FAIL held_eat got %0d want 0", bus.score); end
    bus.eat = 1'b0; tick(); bus.eat = 1'b1; tick();
    n_vec++; if (bus.score !== 4'd1) begin n_err++; $display("FAIL held_eat_rerise got %0d want 1", bus.score); end
    bus.eat = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.start     = ($urandom_range(0, 24) == 0);
      bus.game_over = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) bus.eat = ~bus.eat;
      tick();
      n_vec++;
      if (bus.score !== 4'(m_score) || bus.best !== 4'(m_best) || bus.new_best !== m_new_best ||
          bus.playing !== m_playing || bus.disp_value !== 4'(exp_disp())) begin
        n_err++;
        $display("FAIL random cyc %0d got s=%0d b=%0d n=%0b p=%0b d=%0d want s=%0d b=%0d n=%0b p=%0b d=%0d",
                 i, bus.score, bus.best, bus.new_best, bus.playing, bus.disp_value,
                 m_score, m_best, m_new_best, m_playing, exp_disp());
      end
    end
    rst = 1'b0; drive(0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0);
    test_reset();
    test_count();
    test_saturate();
    test_rounds();
    test_blink();
    test_coincident();
    test_rst_over();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
